// File: rtl/uart_irq_sched_pkg.sv
// Shared definitions for the UART interrupt scheduler: FSM state encoding,
// default source/vector sizes and the vector-register bit layout.
package uart_irq_sched_pkg;

  localparam int unsigned N_SRC_DEF = 6;
  localparam int unsigned VEC_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_SERVICE = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  // Vector register as seen by the CPU through the EBI register file.
  typedef struct packed {
    logic       vec_valid;
    logic [3:0] rsvd;
    logic [2:0] vec;
  } vec_reg_t;

  function automatic vec_reg_t pack_vec_reg(input logic valid, input logic [2:0] vec);
    vec_reg_t r;
    r.vec_valid = valid;
    r.rsvd      = 4'b0;
    r.vec       = vec;
    return r;
  endfunction

endpackage

// File: rtl/uart_irq_sched_rr_pick.sv
// Combinational round-robin find-first: first set bit of req searching
// upward from ptr+1, wrapping from N_SRC-1 to 0.
module rr_pick #(
  parameter int unsigned N_SRC = 6,
  parameter int unsigned VEC_W = 3
) (
  input  logic [N_SRC-1:0] req,
  input  logic [VEC_W-1:0] ptr,
  output logic [VEC_W-1:0] grant_idx,
  output logic             any
);

  // Scan farthest offset first so the nearest requester overwrites.
  always_comb begin
    int idx;
    grant_idx = '0;
    for (int off = int'(N_SRC); off >= 1; off--) begin
      idx = int'(ptr) + off;
      if (idx >= int'(N_SRC)) idx = idx - int'(N_SRC);
      if (req[VEC_W'(idx)]) grant_idx = VEC_W'(idx);
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_irq_sched.sv
// Six-channel UART interrupt scheduler: mask, round-robin pick, ack/eoi
// handshake with post-service gap. UART_IRQ_TIMEOUT_EN adds a service watchdog.
module uart_irq_sched
  import uart_irq_sched_pkg::*;
#(
  parameter int unsigned N_SRC   = N_SRC_DEF,
  parameter int unsigned VEC_W   = VEC_W_DEF,
  parameter int unsigned GAP_CYC = 4
`ifdef UART_IRQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_i,
  input  logic [N_SRC-1:0] irq_mask_i,
  input  logic             ack_i,
  input  logic             eoi_i,
  output logic             int_o,
  output logic [VEC_W-1:0] vec_o,
  output logic             vec_valid_o,
  output logic [N_SRC-1:0] pend_o,
  output logic             busy_o
`ifdef UART_IRQ_TIMEOUT_EN
  , output logic           timeout_o
`endif
);

  localparam int unsigned GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  state_t             state, state_n;
  logic [VEC_W-1:0]   rr_ptr, rr_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic               int_n, vv_n;
  logic [VEC_W-1:0]   vec_n;
  logic [VEC_W-1:0]   grant_idx;
  logic               grant_any;
  logic               tmo_hit;

`ifdef UART_IRQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic             tout_n;
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  rr_pick #(.N_SRC(N_SRC), .VEC_W(VEC_W)) u_rr_pick (
    .req       (pend_o),
    .ptr       (rr_ptr),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    state_n = state;
    int_n   = int_o;
    vec_n   = vec_o;
    vv_n    = vec_valid_o;
    rr_n    = rr_ptr;
    gap_n   = gap_cnt;
`ifdef UART_IRQ_TIMEOUT_EN
    tmo_n   = tmo_cnt;
    tout_n  = 1'b0;
`endif
    case (state)
      ST_IDLE: if (|pend_o) state_n = ST_ARB;
      ST_ARB: begin
        if (grant_any) begin
          vec_n   = grant_idx;
          vv_n    = 1'b1;
          int_n   = 1'b1;
          state_n = ST_ASSERT;
        end else begin
          state_n = ST_IDLE;
        end
      end
      // Ack beats a simultaneous withdrawal; eoi is meaningless here.
      ST_ASSERT: begin
        if (ack_i) begin
          int_n   = 1'b0;
          state_n = ST_SERVICE;
`ifdef UART_IRQ_TIMEOUT_EN
          tmo_n   = '0;
`endif
        end else if (!pend_o[vec_o]) begin
          int_n   = 1'b0;
          vv_n    = 1'b0;
          state_n = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi_i || tmo_hit) begin
          rr_n    = vec_o;
          vv_n    = 1'b0;
          gap_n   = '0;
          state_n = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
`ifdef UART_IRQ_TIMEOUT_EN
          tout_n  = !eoi_i;
`endif
        end else begin
`ifdef UART_IRQ_TIMEOUT_EN
          tmo_n   = tmo_cnt + 1'b1;
`endif
        end
      end
      ST_GAP: begin
        if (gap_cnt >= GAP_W'(GAP_CYC - 1)) state_n = ST_IDLE;
        else                                gap_n   = gap_cnt + 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pend_o      <= '0;
      int_o       <= 1'b0;
      vec_o       <= '0;
      vec_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      rr_ptr      <= VEC_W'(N_SRC - 1);
      gap_cnt     <= '0;
`ifdef UART_IRQ_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_o   <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      pend_o      <= irq_i & ~irq_mask_i;
      int_o       <= int_n;
      vec_o       <= vec_n;
      vec_valid_o <= vv_n;
      busy_o      <= (state_n != ST_IDLE);
      rr_ptr      <= rr_n;
      gap_cnt     <= gap_n;
`ifdef UART_IRQ_TIMEOUT_EN
      tmo_cnt     <= tmo_n;
      timeout_o   <= tout_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_irq_sched.sv
// Self-checking bench for uart_irq_sched: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_uart_irq_sched;

  localparam int N   = 6;
  localparam int GAP = 4;
`ifdef UART_IRQ_TIMEOUT_EN
  localparam int TMO = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] irq = '0, mask = '0;
  logic       ack = 1'b0, eoi = 1'b0;
  logic       int_o, vec_valid_o, busy_o;
  logic [2:0] vec_o;
  logic [5:0] pend_o;
  logic       tout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_irq_sched #(
    .N_SRC(N), .VEC_W(3), .GAP_CYC(GAP)
`ifdef UART_IRQ_TIMEOUT_EN
    , .TIMEOUT_CYC(TMO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .irq_i(irq), .irq_mask_i(mask),
    .ack_i(ack), .eoi_i(eoi), .int_o(int_o), .vec_o(vec_o),
    .vec_valid_o(vec_valid_o), .pend_o(pend_o), .busy_o(busy_o)
`ifdef UART_IRQ_TIMEOUT_EN
    , .timeout_o(tout)
`endif
  );

`ifndef UART_IRQ_TIMEOUT_EN
  assign tout = 1'b0;
`endif

  // Reference model: phase of the current interrupt transaction.
  typedef enum int {P_IDLE, P_ARB, P_ASSERT, P_SERVICE, P_GAP} phase_t;
  phase_t     m_phase;
  logic [5:0] m_pend;
  logic       m_int, m_vv, m_busy, m_tout;
  int         m_vec, m_last, m_gap_left, m_svc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_next(input logic [5:0] p, input int last);
    for (int k = 1; k <= N; k++)
      if (p[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_pend = '0; m_int = 0; m_vv = 0; m_busy = 0;
    m_tout = 0; m_vec = 0; m_last = N - 1; m_gap_left = 0; m_svc = 0;
  endtask

  task automatic model_step();
    logic [5:0] old_pend;
    logic       done;
    old_pend = m_pend;
    m_pend   = irq & ~mask;
    m_tout   = 0;
    case (m_phase)
      P_IDLE: if (old_pend != 0) m_phase = P_ARB;
      P_ARB: begin
        if (old_pend == 0) m_phase = P_IDLE;
        else begin
          m_vec = rr_next(old_pend, m_last); m_vv = 1; m_int = 1; m_phase = P_ASSERT;
        end
      end
      P_ASSERT: begin
        if (ack) begin m_int = 0; m_svc = 0; m_phase = P_SERVICE; end
        else if (!old_pend[m_vec]) begin m_int = 0; m_vv = 0; m_phase = P_IDLE; end
      end
      P_SERVICE: begin
        m_svc++;
        done = eoi;
`ifdef UART_IRQ_TIMEOUT_EN
        if (!eoi && m_svc == TMO) begin done = 1; m_tout = 1; end
`endif
        if (done) begin
          m_last = m_vec; m_vv = 0; m_gap_left = GAP;
          m_phase = (GAP > 0) ? P_GAP : P_IDLE;
        end
      end
      P_GAP: begin
        m_gap_left--;
        if (m_gap_left == 0) m_phase = P_IDLE;
      end
      default: m_phase = P_IDLE;
    endcase
    m_busy = (m_phase != P_IDLE);
  endtask

  // One clock: advance the model with the sampled inputs, then compare.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    chk("cycle_outputs", {20'd0, int_o, vec_o, vec_valid_o, pend_o, busy_o},
        {20'd0, m_int, 3'(m_vec), m_vv, m_pend, m_busy});
    chk("timeout_pulse", {31'd0, tout}, {31'd0, m_tout});
  endtask

  task automatic wait_int(input int budget);
    int n = 0;
    while (!int_o && n < budget) begin tick(); n++; end
    chk("wait_int_in_budget", {31'd0, int_o}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {20'd0, int_o, vec_o, vec_valid_o, pend_o, busy_o, tout}, 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [5:0] irq, mask;
    logic       ack, eoi;
    logic       e_int;
    logic [2:0] e_vec;
    logic       e_vv;
    logic [5:0] e_pend;
    logic       e_busy;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int low_cnt;
    int n;
    tbl[0]  = '{6'h01, 6'h00, 0, 0, 0, 3'd0, 0, 6'h01, 0};
    tbl[1]  = '{6'h01, 6'h00, 0, 0, 0, 3'd0, 0, 6'h01, 1};
    tbl[2]  = '{6'h01, 6'h00, 0, 0, 1, 3'd0, 1, 6'h01, 1};
    tbl[3]  = '{6'h01, 6'h00, 1, 0, 0, 3'd0, 1, 6'h01, 1};
    tbl[4]  = '{6'h00, 6'h00, 0, 1, 0, 3'd0, 0, 6'h00, 1};
    tbl[5]  = '{6'h00, 6'h00, 0, 0, 0, 3'd0, 0, 6'h00, 1};
    tbl[6]  = '{6'h00, 6'h00, 0, 0, 0, 3'd0, 0, 6'h00, 1};
    tbl[7]  = '{6'h00, 6'h00, 0, 0, 0, 3'd0, 0, 6'h00, 1};
    tbl[8]  = '{6'h00, 6'h00, 0, 0, 0, 3'd0, 0, 6'h00, 0};
    tbl[9]  = '{6'h00, 6'h00, 1, 1, 0, 3'd0, 0, 6'h00, 0};
    tbl[10] = '{6'h24, 6'h04, 0, 0, 0, 3'd0, 0, 6'h20, 0};
    tbl[11] = '{6'h24, 6'h04, 0, 0, 0, 3'd0, 0, 6'h20, 1};
    tbl[12] = '{6'h24, 6'h04, 0, 0, 1, 3'd5, 1, 6'h20, 1};
    tbl[13] = '{6'h24, 6'h04, 1, 0, 0, 3'd5, 1, 6'h20, 1};
    tbl[14] = '{6'h00, 6'h04, 0, 1, 0, 3'd5, 0, 6'h00, 1};
    tbl[15] = '{6'h00, 6'h04, 0, 0, 0, 3'd5, 0, 6'h00, 1};
    tbl[16] = '{6'h00, 6'h04, 0, 0, 0, 3'd5, 0, 6'h00, 1};
    tbl[17] = '{6'h00, 6'h04, 0, 0, 0, 3'd5, 0, 6'h00, 1};
    tbl[18] = '{6'h00, 6'h00, 0, 0, 0, 3'd5, 0, 6'h00, 0};

    model_reset();
    #1;
    chk("reset_outputs", {20'd0, int_o, vec_o, vec_valid_o, pend_o, busy_o, tout}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Directed vectors: single source, gap length, ignored strobes, masking.
    for (int i = 0; i < 19; i++) begin
      irq = tbl[i].irq; mask = tbl[i].mask; ack = tbl[i].ack; eoi = tbl[i].eoi;
      tick();
      chk($sformatf("table_row_%0d", i), {20'd0, int_o, vec_o, vec_valid_o, pend_o, busy_o},
          {20'd0, tbl[i].e_int, tbl[i].e_vec, tbl[i].e_vv, tbl[i].e_pend, tbl[i].e_busy});
    end
    ack = 0; eoi = 0;

    // Withdrawal in ASSERT cancels without moving the round-robin pointer.
    irq = 6'h08;
    wait_int(10);
    chk("cancel_vec", 32'(vec_o), 32'd3);
    eoi = 1; tick(); eoi = 0;
    chk("eoi_in_assert_ignored", {30'd0, int_o, vec_valid_o}, 32'd3);
    irq = 6'h00; tick(); tick();
    chk("cancel_outputs", {29'd0, int_o, vec_valid_o, busy_o}, 32'd0);
    irq = 6'h18;
    wait_int(10);
    chk("rr_ptr_unchanged_after_cancel", 32'(vec_o), 32'd3);

    // Ack and eoi together: only ack applies, SERVICE is held.
    ack = 1; eoi = 1; tick(); ack = 0; eoi = 0;
    chk("ack_eoi_same_cycle", {29'd0, int_o, vec_valid_o, busy_o}, 32'd3);
    tick();
    chk("still_in_service", {29'd0, int_o, vec_valid_o, busy_o}, 32'd3);
    irq = 6'h00;
    do_reset();

    // Round-robin fairness with every source pending.
    irq = 6'h3f; mask = 6'h00;
    low_cnt = 0;
    for (int g = 0; g < 7; g++) begin
      n = 0;
      while (!int_o && n < 30) begin tick(); n++; low_cnt++; end
      chk($sformatf("rr_grant_%0d", g), 32'(vec_o), 32'(g % N));
      if (g > 0) chk("int_low_gap_ge4", {31'd0, (low_cnt >= 4)}, 32'd1);
      ack = 1; tick(); ack = 0;
      eoi = 1; tick(); eoi = 0;
      low_cnt = 2;
    end

    // Long service without eoi.
    wait_int(30);
    ack = 1; tick(); ack = 0;
`ifdef UART_IRQ_TIMEOUT_EN
    n = 0;
    while (!tout && n < 100) begin tick(); n++; end
    chk("timeout_after_cycles", 32'(n), 32'(TMO));
    tick();
    chk("timeout_single_pulse", {30'd0, tout, busy_o}, 32'd1);
`else
    for (int c = 0; c < 1000; c++) tick();
    chk("service_held_1000", {29'd0, int_o, vec_valid_o, busy_o}, 32'd3);
    eoi = 1; tick(); eoi = 0;
`endif
    irq = 6'h00;
    for (int c = 0; c < 8; c++) tick();

    // Randomized traffic, strobes at arbitrary times, occasional reset.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) irq = irq ^ 6'(1 << $urandom_range(5));
      if ($urandom_range(31) == 0) mask = 6'($urandom);
      ack = ($urandom_range(3) == 0);
      eoi = ($urandom_range(3) == 0);
      if (c % 997 == 500) do_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_irq_sched.md
Name: uart_irq_sched

Overview:
- Interrupt scheduler for the six on-chip UART channels (A–F).
- Collects the per-UART interrupt levels, applies a CPU-written mask, and picks one source by round-robin.
- Drives a single interrupt line to the PowerPC, with a vector identifying the winning UART.
- Runs an ack / end-of-interrupt handshake so only one UART is in service at a time. Sits between the UART int outputs and the EBI register file, which supplies the mask, ack and eoi strobes and returns vector and pending status.

Parameters:
- N_SRC, 6, number of interrupt sources (UART channels).
- VEC_W, 3, vector width; must satisfy 2**VEC_W >= N_SRC.
- GAP_CYC, 4, minimum cycles with int_o low between consecutive interrupts; 0 disables the gap.
- TIMEOUT_CYC, 65535, service watchdog limit; used only with UART_IRQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; same clock as UARTs and register file.
- rst  in  1  asynchronous, active-high reset.
- irq_i  in  N_SRC  level interrupt from each UART; bit 0 = UART A.
- irq_mask_i  in  N_SRC  1 = source masked; held by register file.
- ack_i  in  1  one-cycle pulse when the CPU reads the vector register.
- eoi_i  in  1  one-cycle pulse when the CPU writes end-of-interrupt.
- int_o  out  1  interrupt request to CPU, active-high.
- vec_o  out  VEC_W  index of the granted source.
- vec_valid_o  out  1  vec_o holds a live grant.
- pend_o  out  N_SRC  irq_i & ~irq_mask_i, registered.
- busy_o  out  1  state != IDLE.
- timeout_o  out  1  one-cycle watchdog pulse; present only with UART_IRQ_TIMEOUT_EN.

Behaviour:
- Reset values: int_o=0, vec_o=0, vec_valid_o=0, pend_o=0, busy_o=0, timeout_o=0, state=IDLE, rr_ptr=N_SRC-1 (so source 0 wins first), gap counter=0.
- pend_o is registered every cycle: pend_o <= irq_i & ~irq_mask_i. All decisions use pend_o, giving 1 cycle of latency from irq_i.
- IDLE: if pend_o != 0, go to ARB. Otherwise stay.
- ARB (1 cycle):
  - Winner = first set bit of pend_o, searching upward from rr_ptr+1 and wrapping from N_SRC-1 to 0.
  - Latch vec_o = winner, set vec_valid_o=1, go to ASSERT.
  - If pend_o becomes 0 in this cycle, return to IDLE with no grant.
- ASSERT: int_o=1.
  - ack_i: int_o<=0, go to SERVICE.
  - Else if pend_o[vec_o]==0 (source withdrew or was masked): cancel. int_o<=0, vec_valid_o<=0, go to IDLE; rr_ptr is unchanged.
  - If ack_i and withdrawal happen in the same cycle, ack wins.
- SERVICE: int_o=0, vec_valid_o=1. Source state is ignored here.
  - eoi_i: rr_ptr<=vec_o, vec_valid_o<=0. Go to GAP if GAP_CYC>0, else to IDLE.
- GAP: count GAP_CYC cycles, then go to IDLE. int_o stays 0.
- Interrupt-to-int_o latency: an irq_i rising at cycle t gives int_o=1 at t+3 (pend reg, IDLE→ARB, ARB→ASSERT).
- Ignored strobes:
  - ack_i outside ASSERT is ignored.
  - eoi_i outside SERVICE is ignored.
  - If ack_i and eoi_i arrive in the same ASSERT cycle, only ack takes effect.
- Mask changes affect the next arbitration only, except for the cancel rule in ASSERT.
- Asynchronous rst in any state returns immediately to the reset values; any in-flight grant is lost.
- The gap counter is $clog2(GAP_CYC+1) bits and saturates at terminal count.

Optional Feature:
- Macro UART_IRQ_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYC+1) bits runs in SERVICE and clears on entry.
  - When it reaches TIMEOUT_CYC without eoi_i, the block behaves exactly as for eoi_i (rr_ptr<=vec_o, vec_valid_o<=0, then GAP/IDLE) and pulses timeout_o for 1 cycle.
  - If eoi_i coincides with terminal count, treat it as a normal eoi: no timeout_o pulse.
- Not defined: no counter and no timeout_o port. SERVICE waits indefinitely for eoi_i.

Decomposition:
- Shared package/include uart_irq_defs: state encodings (IDLE, ARB, ASSERT, SERVICE, GAP), default N_SRC and VEC_W, and the register-file vector-register bit layout ({vec_valid, 4'b0, vec}).
- One sub-module: rr_pick, a combinational round-robin find-first.
  - Inputs: req[N_SRC], ptr[VEC_W]. Outputs: grant_idx, any.
  - Instantiated once in the ARB datapath.

Test Plan:
- Reset then irq_i=6'b000001 → int_o=1 three cycles later, vec_o=0. ack_i → int_o=0. eoi_i → busy_o stays high for 4 GAP cycles, then IDLE.
- irq_i=6'b111111 held, ack+eoi each grant → grant order 0,1,2,3,4,5,0. int_o low ≥4 cycles between grants.
- irq_i=6'b100100, irq_mask_i=6'b000100 → only vec_o=5 granted. pend_o=6'b100000.
- In ASSERT with vec_o=3, drop irq_i[3] before ack → int_o=0, vec_valid_o=0, back to IDLE. The next grant still searches from rr_ptr+1 (unchanged).
- ack_i pulsed in IDLE and eoi_i pulsed in ASSERT → no state change. Assert rst in SERVICE → all outputs 0 the same cycle.
- UART_IRQ_TIMEOUT_EN, TIMEOUT_CYC=16: ack, no eoi → timeout_o pulses once after 16 SERVICE cycles, then GAP. Without the macro, SERVICE holds for 1000 cycles.
